// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter.
// Sends start, DATA_BITS data bits (LSB first), optional parity, and 1 or 2
// stop bits. Bit timing comes from an external oversample tick (b_tick).
// tx, tx_busy and tx_done are all registered, so every output change
// happens on the same edge as the state change that causes it.
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 start_trigger,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   two_stop_q, two_stop_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   in_bit;
    logic                   bit_end;

    // A bit period is running in these states; a bit ends on its last tick.
    assign in_bit  = (state_q == S_START) || (state_q == S_DATA) ||
                     (state_q == S_PARITY) || (state_q == S_STOP);
    assign bit_end = in_bit && b_tick && (tick_cnt_q == TICK_LAST);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // Tick counting shared by all bit states; it never passes TICK_LAST.
        if (in_bit && b_tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start_trigger) begin
                    shift_d    = tx_data;
                    par_en_d   = parity_en;
                    par_bit_d  = (^tx_data) ^ parity_odd;
                    two_stop_d = two_stop;
                    busy_d     = 1'b1;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                // First tick after accept starts the start bit on the tick grid.
                if (b_tick) begin
                    tick_cnt_d = '0;
                    tx_d       = 1'b0;
                    state_d    = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q != BIT_LAST) begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[1];
                    end else if (par_en_q) begin
                        tx_d    = par_bit_q;
                        state_d = S_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that abandons a frame.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg.
// Two instances: 8-bit / x16 and 7-bit / x8. Expected line behaviour is
// derived from the frame's bit list and the number of ticks seen since the
// frame was accepted: after tick n (n >= 1) the line carries bit (n-1)/OS,
// and the tick that completes the last bit ends the frame with a done pulse.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       b_tick;
    logic       start_a, start_b;
    logic [8:0] data;
    logic       pen, podd, two;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;
    int phase    = 0;

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       pen;
        logic       podd;
        logic       two;
        logic       exp_par;
        int         div;
        string      name;
    } vec_t;

    vec_t vecs[7];

    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) dut_a (
        .clk(clk), .rst(rst), .b_tick(b_tick), .start_trigger(start_a),
        .tx_data(data[7:0]), .parity_en(pen), .parity_odd(podd), .two_stop(two),
        .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8)) dut_b (
        .clk(clk), .rst(rst), .b_tick(b_tick), .start_trigger(start_b),
        .tx_data(data[6:0]), .parity_en(pen), .parity_odd(podd), .two_stop(two),
        .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [2:0] sample(input int sel);
        return (sel != 0) ? {tx_b, busy_b, done_b} : {tx_a, busy_a, done_a};
    endfunction

    // div = 0: random ticks; otherwise one tick every div clocks.
    task automatic drive_tick(input int div);
        if (div == 0) begin
            b_tick = ($urandom_range(0, 2) == 0);
        end else begin
            phase++;
            b_tick = ((phase % div) == 0);
        end
    endtask

    task automatic idle_check(input int sel, input string name);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        b_tick  = 1'b0;
        @(posedge clk);
        #1;
        check({name, " idle after"}, sample(sel), 3'b100);
    endtask

    // Send one frame and compare {tx, busy, done} on every clock.
    // hold=1 keeps start_trigger high and inputs stable (back-to-back frames);
    // abort_at>0 returns once that many ticks have been seen.
    task automatic send_frame(input int sel, input logic [8:0] d, input logic p_en,
                              input logic p_odd, input logic t_stop, input logic exp_par,
                              input int div, input bit hold, input int abort_at,
                              input string name);
        int       db, os, nbits, n, k, cyc, c_start, limit;
        logic     bits[$];
        logic [2:0] exp;
        db = (sel != 0) ? 7 : 8;
        os = (sel != 0) ? 8 : 16;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) bits.push_back(d[i]);
        if (p_en) bits.push_back(exp_par);
        bits.push_back(1'b1);
        if (t_stop) bits.push_back(1'b1);
        nbits = bits.size();

        @(negedge clk);
        data = d; pen = p_en; podd = p_odd; two = t_stop;
        if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
        b_tick = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        check({name, " accept"}, sample(sel), 3'b110);

        n = 0; cyc = 0; c_start = -1;
        limit = (nbits * os + 2) * ((div == 0) ? 12 : div) + 20;
        while (n < 1 + nbits * os) begin
            if (abort_at > 0 && n >= abort_at) return;
            if (cyc >= limit) begin
                checks++;
                failures++;
                $display("FAIL %s timeout: ticks %0d required %0d", name, n, 1 + nbits * os);
                return;
            end
            @(negedge clk);
            if (!hold) begin
                if (sel != 0) start_b = ($urandom_range(0, 7) == 0);
                else          start_a = ($urandom_range(0, 7) == 0);
                data = 9'($urandom);
                pen  = 1'($urandom);
                podd = 1'($urandom);
                two  = 1'($urandom);
            end
            drive_tick(div);
            @(posedge clk);
            #1;
            cyc++;
            if (b_tick) n++;
            if (n == 1 && c_start < 0) c_start = cyc;
            if (n == 0) begin
                exp = 3'b110;
            end else begin
                k = (n - 1) / os;
                exp = (k < nbits) ? {bits[k], 2'b10} : 3'b101;
            end
            check($sformatf("%s cyc%0d", name, cyc), sample(sel), exp);
        end
        if (div > 0) check({name, " frame length"}, cyc - c_start, nbits * os * div);
        if (!hold) idle_check(sel, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         sel, div;
        logic [8:0] d, mask;
        logic       p, o, t;

        vecs[0] = '{0, 9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 4, "t1_0x55"};
        vecs[1] = '{0, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0, 4, "t2_even"};
        vecs[2] = '{0, 9'h0A5, 1'b1, 1'b1, 1'b0, 1'b1, 2, "t2_odd"};
        vecs[3] = '{0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4, "t3_two_stop"};
        vecs[4] = '{1, 9'h041, 1'b1, 1'b1, 1'b0, 1'b1, 1, "t6_7bit_odd"};
        vecs[5] = '{1, 9'h02A, 1'b1, 1'b0, 1'b1, 1'b1, 3, "b_7bit_even_2stop"};
        vecs[6] = '{0, 9'h0FF, 1'b1, 1'b1, 1'b0, 1'b1, 0, "ff_odd_rand_tick"};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; b_tick = 1'b0;
        data = '0; pen = 1'b0; podd = 1'b0; two = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset a", {tx_a, busy_a, done_a}, 3'b100);
        check("reset b", {tx_b, busy_b, done_b}, 3'b100);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].pen, vecs[i].podd, vecs[i].two,
                       vecs[i].exp_par, vecs[i].div, 1'b0, 0, vecs[i].name);
        end

        // Start held high: three identical frames back to back.
        for (int f = 0; f < 3; f++) begin
            send_frame(0, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 0,
                       $sformatf("t4_chain%0d", f));
        end
        idle_check(0, "t4_chain_end");

        // Reset in the middle of data bit 3, then a clean frame.
        send_frame(0, 9'h0C3, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1 + 4 * 16 + 5, "t5_pre");
        @(negedge clk);
        rst = 1'b1; start_a = 1'b0; b_tick = 1'b1;
        @(posedge clk);
        #1;
        check("t5 reset mid-frame", {tx_a, busy_a, done_a}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            b_tick = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check($sformatf("t5 idle after reset %0d", c), {tx_a, busy_a, done_a}, 3'b100);
        end
        send_frame(0, 9'h081, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 0, "t5_0x81");

        // Randomised frames on both instances.
        for (int r = 0; r < 8; r++) begin
            sel  = $urandom_range(0, 1);
            div  = $urandom_range(0, 3);
            d    = 9'($urandom);
            p    = 1'($urandom);
            o    = 1'($urandom);
            t    = 1'($urandom);
            mask = (sel != 0) ? 9'h07F : 9'h0FF;
            send_frame(sel, d & mask, p, o, t, (^(d & mask)) ^ o, div, 1'b0, 0,
                       $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the stopwatch/sensor UART path. Supports configurable data width and oversampling, plus per-frame parity (none/even/odd) and 1 or 2 stop bits. Driven by the shared baud-tick generator (b_tick at OVERSAMPLE x baud). Adds a one-cycle tx_done strobe so the upstream FIFO/printer can chain frames without polling tx_busy.

Parameters:
DATA_BITS, 8, frame data width; legal 5..9.
OVERSAMPLE, 16, b_tick pulses per bit period; legal 4..32.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous active-high reset.
b_tick  input  1  one-clk oversample tick from the baud generator.
start_trigger  input  1  request to send; sampled only in IDLE.
tx_data  input  DATA_BITS  frame payload; sent LSB first.
parity_en  input  1  1 = append parity bit.
parity_odd  input  1  0 = even parity, 1 = odd; ignored if parity_en=0.
two_stop  input  1  1 = two stop bits, 0 = one.
tx  output  1  serial line; idle high.
tx_busy  output  1  high from accept until the frame ends.
tx_done  output  1  one-clk pulse at the end of the stop period.

Behaviour:
- Reset (synchronous, rst=1 at a posedge clk): state=IDLE, tx=1, tx_busy=0, tx_done=0, all counters and shift register 0. Applies mid-frame. The frame is abandoned; the line returns high on that edge.
- tx, tx_busy and tx_done are registered. Every output change occurs on the clock edge that performs the corresponding state transition.
- States: IDLE, WAIT, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_busy=0.
  - If start_trigger=1, on that edge: latch tx_data into the shift register; latch parity_en, parity_odd and two_stop; compute the parity bit (XOR of tx_data, inverted if parity_odd); set tx_busy=1; go to WAIT.
  - start_trigger in any other state is ignored. No queueing.
- WAIT: aligns to the tick grid. On the first b_tick: tick_cnt=0, tx=0, go to START.
- Bit timing, all bit states: count b_tick from 0. On a b_tick with tick_cnt=OVERSAMPLE-1, the bit ends: tick_cnt=0 and the next bit value is driven onto tx on the same edge. Each bit therefore lasts exactly OVERSAMPLE ticks.
- START ends -> DATA. bit_cnt=0, tx=shift[0].
- DATA, at each bit end:
  - If bit_cnt<DATA_BITS-1: shift right, bit_cnt+1, tx=new shift[0].
  - Otherwise go to PARITY (tx=parity bit) if parity_en=1, else to STOP (tx=1, stop_cnt=0).
- PARITY ends -> STOP, tx=1, stop_cnt=0.
- STOP: tx=1. At bit end:
  - If two_stop=1 and stop_cnt=0: stop_cnt=1 and remain in STOP.
  - Otherwise: go to IDLE with tx_busy=0 and tx_done=1 for exactly one clk.
- Frame accepted on the same edge tx_busy falls: not possible. In IDLE, tx_busy is already 0 and start_trigger is accepted on the first IDLE cycle. Back-to-back frames are spaced by IDLE(1 clk) + WAIT (up to one tick period).
- b_tick outside WAIT/bit states has no effect. The b_tick and start_trigger edge in IDLE: trigger wins, tick is not counted.
- Counter widths: tick_cnt is clog2(OVERSAMPLE) bits, bit_cnt is clog2(DATA_BITS) bits. Neither counter ever wraps past its terminal value.
- Config inputs and tx_data may change freely while tx_busy=1; the in-flight frame is unaffected.

Test Plan:
1. DATA_BITS=8, OVERSAMPLE=16, b_tick every 4 clk, tx_data=0x55, parity_en=0, two_stop=0 -> tx = 0,1,0,1,0,1,0,1,0,1 with each bit exactly 64 clk; tx_busy high from the edge after trigger until the STOP end; one tx_done pulse.
2. tx_data=0xA5, parity_en=1, parity_odd=0 -> parity bit 0 after the 8 data bits; repeat with parity_odd=1 -> parity bit 1; frame is 11 bit periods.
3. tx_data=0x00, two_stop=1 -> stop high for 32 ticks (128 clk) before tx_done; start_trigger pulsed during STOP is ignored (no second frame).
4. start_trigger held high continuously with tx_data=0x3C -> consecutive identical frames; each is preceded by a 1-clk IDLE and WAIT tick alignment; tx_done pulses once per frame.
5. rst=1 for one clk during DATA bit 3 -> on that edge tx=1, tx_busy=0, tx_done=0; next trigger with 0x81 produces a clean full frame.
6. Instance with DATA_BITS=7, OVERSAMPLE=8, tx_data=7'h41, parity_en=1, parity_odd=1 -> start, 1,0,0,0,0,0,1, parity 1, stop; each bit is 8 ticks.
